display_fetcher: RTL

//  Read-side master for the display frame memory: walks word addresses 0..N_WORDS-1,

---
 rtl/display_pkg.sv | 28 ++
 rtl/display_fetcher_if.sv | 26 ++
 rtl/fetch_fifo2.sv | 43 ++++
 rtl/display_fetcher.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared defaults, FSM encoding and read-credit helper for the display frame fetcher.
package display_pkg;

    localparam int DEFAULT_N_WORDS = 3201;
    localparam int DEFAULT_ADDR_W  = 12;
    localparam int DEFAULT_DATA_W  = 36;
    localparam int DEFAULT_PIX_W   = 12;

    // Words that may be held at once: FIFO + capture + request + word being unpacked.
    localparam int CREDIT_WORDS = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } fetch_state_t;

    // True when one more read can be issued without exceeding the word credit.
    function automatic logic credit_free(
        input logic [1:0] queued,
        input logic       pending,
        input logic       requested,
        input logic       unpacking
    );
        return (int'(queued) + int'(pending) + int'(requested) + int'(unpacking)) < CREDIT_WORDS;
    endfunction

endpackage

// File: rtl/display_fetcher_if.sv
// RAM read port and pixel stream of the display fetcher; master = fetcher side.
interface display_fetcher_if
    import display_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int PIX_W  = DEFAULT_PIX_W
);
    logic              request;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] valor;
    logic [PIX_W-1:0]  pix;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;

    modport master (
        output request, addr, pix, pix_valid, pix_last,
        input  valor, pix_ready
    );

    modport slave (
        input  request, addr, pix, pix_valid, pix_last,
        output valor, pix_ready
    );
endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry word FIFO between RAM capture and the pixel unpacker; synchronous reset.
module fetch_fifo2
    import display_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        count,
    output logic              empty
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    // NOTE: the storage array is deliberately not reset; count and pointers alone mark entries valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == 2'd0);

endmodule

// File: rtl/display_fetcher.sv
// Frame-memory read master: fetches words 0..N_WORDS-1 under a 2-word credit and
// unpacks each word into three pixels. Define FRAME_LOOP_EN for continuous refresh.
module display_fetcher
    import display_pkg::*;
#(
    parameter int N_WORDS = DEFAULT_N_WORDS,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int PIX_W   = DEFAULT_PIX_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    display_fetcher_if.master bus
);

`ifdef FRAME_LOOP_EN
    localparam bit LOOP_FRAMES = 1'b1;
`else
    localparam bit LOOP_FRAMES = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

    fetch_state_t      state;
    logic              busy;
    logic              request;
    logic              rd_pend;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] issue_at;
    logic              issue;
    logic              issue_last;

    logic [DATA_W-1:0] fifo_rdata;
    logic [1:0]        fifo_count;
    logic              fifo_empty;

    logic [DATA_W-1:0] word;
    logic [1:0]        pix_sel;
    logic              word_is_last;
    logic [ADDR_W-1:0] pop_cnt;
    logic [PIX_W-1:0]  pix;
    logic              pix_valid;
    logic              pix_last;
    logic              fire;
    logic              word_done;
    logic              pop;

    // Pixel 0 is the most significant slice of the word.
    function automatic logic [PIX_W-1:0] pixel_of(input logic [DATA_W-1:0] w, input logic [1:0] sel);
        return w[(2 - int'(sel)) * PIX_W +: PIX_W];
    endfunction

    fetch_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (rd_pend),
        .pop   (pop),
        .wdata (bus.valor),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign fire      = pix_valid & bus.pix_ready;
    assign word_done = fire && (pix_sel == 2'd2);
    assign pop       = (!pix_valid || word_done) && !fifo_empty;
    assign issue_at  = (state == ST_IDLE) ? '0 : issue_addr;
    assign issue_last = (issue_at == LAST_ADDR);

    // The word under unpacking holds its credit until its last pixel is accepted.
    always_comb begin
        // NOTE: issue is defaulted first so no path through the case leaves it unassigned (no latch).
        issue = 1'b0;
        unique case (state)
            ST_IDLE:  issue = i_start;
            ST_FETCH: issue = credit_free(fifo_count, rd_pend, request, pix_valid & ~word_done);
            default:  issue = 1'b0;
        endcase
    end

    // NOTE: non-blocking assignments throughout; every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            request    <= 1'b0;
            rd_pend    <= 1'b0;
            addr       <= '0;
            issue_addr <= '0;
        end else begin
            rd_pend <= request;
            request <= issue;
            if (issue) begin
                addr       <= issue_at;
                issue_addr <= issue_last ? '0 : issue_at + 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        busy  <= 1'b1;
                        state <= (issue_last && !LOOP_FRAMES) ? ST_DRAIN : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (issue && issue_last && !LOOP_FRAMES) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!request && !rd_pend && fifo_empty && !pix_valid) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word         <= '0;
            pix_sel      <= 2'd0;
            word_is_last <= 1'b0;
            pop_cnt      <= '0;
            pix          <= '0;
            pix_valid    <= 1'b0;
            pix_last     <= 1'b0;
        end else if (pop) begin
            word         <= fifo_rdata;
            pix          <= pixel_of(fifo_rdata, 2'd0);
            pix_sel      <= 2'd0;
            pix_valid    <= 1'b1;
            pix_last     <= 1'b0;
            word_is_last <= (pop_cnt == LAST_ADDR);
            pop_cnt      <= (pop_cnt == LAST_ADDR) ? '0 : pop_cnt + 1'b1;
        end else if (fire) begin
            if (pix_sel == 2'd2) begin
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
            end else begin
                pix_sel  <= pix_sel + 2'd1;
                pix      <= pixel_of(word, pix_sel + 2'd1);
                pix_last <= (pix_sel == 2'd1) && word_is_last;
            end
        end
    end

    assign o_busy        = busy;
    assign bus.request   = request;
    assign bus.addr      = addr;
    assign bus.pix       = pix;
    assign bus.pix_valid = pix_valid;
    assign bus.pix_last  = pix_last;

endmodule
